// File: rtl/ed25519_pkg.sv
// Shared Ed25519 scalar constants, widths and the reducer state encoding.
package ed25519_pkg;

    localparam int unsigned IN_W_DEF = 512;
    localparam int unsigned R_W      = 254;
    localparam int unsigned OUT_W    = 253;

    localparam logic [127:0]     L_C     = 128'h14def9dea2f79cd65812631a5cf5d3ed;
    localparam logic [OUT_W-1:0] L_ORDER = (253'd1 << 252) + {125'd0, L_C};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/mod_l_reduce_512_if.sv
// Operand/result handshake bundle for the mod-l reducer.
interface mod_l_reduce_512_if #(
    parameter int unsigned IN_W = 512
);
    logic            in_valid;
    logic            in_ready;
    logic [IN_W-1:0] in_data;
    logic            out_valid;
    logic            out_ready;
    logic [252:0]    out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/mod_l_reduce_512_step.sv
// One restoring-reduction step: r' = (2r + b) mod ORDER_L, given r < ORDER_L.
module mod_l_step
    import ed25519_pkg::*;
#(
    parameter logic [OUT_W-1:0] ORDER_L = L_ORDER
) (
    input  logic [R_W-1:0] r_i,
    input  logic           bit_i,
    output logic [R_W-1:0] r_o
);
    logic [R_W-1:0] t;
    logic [R_W-1:0] l_ext;
    logic           ge;

    // r < ORDER_L < 2^253, so the top bit of r is always zero and drops out here.
    assign t     = R_W'({r_i, bit_i});
    assign l_ext = {1'b0, ORDER_L};
    assign ge    = (t >= l_ext);
    assign r_o   = ge ? (t - l_ext) : t;

endmodule

// File: rtl/mod_l_reduce_512.sv
// Bit-serial reducer: consumes the operand MSB-first, one bit per enabled cycle.
module mod_l_reduce_512
    import ed25519_pkg::*;
#(
    parameter logic [OUT_W-1:0] ORDER_L = L_ORDER,
    parameter int unsigned      IN_W    = IN_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               CE,
    mod_l_reduce_512_if.slave  bus
);
    localparam int unsigned CNT_W = $clog2(IN_W);

    state_e             state_q, state_d;
    logic [IN_W-1:0]    sreg_q, sreg_d;
    logic [R_W-1:0]     r_q, r_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [OUT_W-1:0]   out_q, out_d;
    logic               in_rdy_q, in_rdy_d;
    logic               out_vld_q, out_vld_d;
    logic [R_W-1:0]     r_step;

    mod_l_step #(.ORDER_L(ORDER_L)) u_step (
        .r_i   (r_q),
        .bit_i (sreg_q[IN_W-1]),
        .r_o   (r_step)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            sreg_q    <= '0;
            r_q       <= '0;
            cnt_q     <= '0;
            out_q     <= '0;
            in_rdy_q  <= 1'b1;
            out_vld_q <= 1'b0;
        end else if (CE) begin
            state_q   <= state_d;
            sreg_q    <= sreg_d;
            r_q       <= r_d;
            cnt_q     <= cnt_d;
            out_q     <= out_d;
            in_rdy_q  <= in_rdy_d;
            out_vld_q <= out_vld_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        sreg_d    = sreg_q;
        r_d       = r_q;
        cnt_d     = cnt_q;
        out_d     = out_q;
        in_rdy_d  = in_rdy_q;
        out_vld_d = out_vld_q;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid && in_rdy_q) begin
                    sreg_d   = bus.in_data;
                    r_d      = '0;
                    cnt_d    = CNT_W'(IN_W - 1);
                    in_rdy_d = 1'b0;
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                r_d    = r_step;
                sreg_d = sreg_q << 1;
                cnt_d  = cnt_q - CNT_W'(1);
                if (cnt_q == '0) begin
                    cnt_d     = '0;
                    out_d     = r_step[OUT_W-1:0];
                    out_vld_d = 1'b1;
                    state_d   = DONE;
                end
            end
            DONE: begin
                // New operands are held off until the result has been taken.
                if (bus.out_ready) begin
                    out_vld_d = 1'b0;
                    in_rdy_d  = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.in_ready  = in_rdy_q;
    assign bus.out_valid = out_vld_q;
    assign bus.out_data  = out_q;

endmodule
